// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: tagged BTB entries with saturating
// direction counters, plus update/mispredict statistics.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              clk_I,
  input  logic              reset_I,
  input  logic [31:0]       ifPc_I,
  output logic              predTaken_O,
  output logic [31:0]       predTarget_O,
  input  logic              updValid_I,
  input  logic [31:0]       updPc_I,
  input  logic              updTaken_I,
  input  logic [31:0]       updTarget_I,
  input  logic              updIsJump_I,
  input  logic              updPredTaken_I,
  input  logic [31:0]       updPredTarget_I,
  input  logic              flush_I,
  output logic [STAT_W-1:0] branchCount_O,
  output logic [STAT_W-1:0] mispredCount_O
);

  localparam int IDX_W = $clog2(ENTRIES);

  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_WKT  =
    CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WKNT =
    CTR_WKT - CTR_W'(1);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [ENTRIES-1:0] validQ;
  logic [TAG_W-1:0]   tagMem [ENTRIES];
  logic [31:0]        tgtMem [ENTRIES];
  logic [CTR_W-1:0]   ctrMem [ENTRIES];

  // Lookup side
  logic [IDX_W-1:0] lkIdx;
  logic [TAG_W-1:0] lkTag;
  logic             lkHit;

  assign lkIdx = ifPc_I[IDX_W+1:2];
  assign lkTag = ifPc_I[IDX_W+TAG_W+1:IDX_W+2];
  assign lkHit = validQ[lkIdx]
              && (tagMem[lkIdx] == lkTag);

  assign predTaken_O  = lkHit
                     && ctrMem[lkIdx][CTR_W-1];
  assign predTarget_O = predTaken_O
                      ? tgtMem[lkIdx]
                      : ifPc_I + 32'd4;

  // Update side
  logic [IDX_W-1:0] updIdx;
  logic [TAG_W-1:0] updTag;
  logic             updHit;
  logic             wrEn;
  logic             doAlloc;
  logic             doTrain;
  logic [CTR_W-1:0] curCtr;
  logic [CTR_W-1:0] trainCtr;
  logic [CTR_W-1:0] allocCtr;
  logic             unusedPc;

  assign updIdx  = updPc_I[IDX_W+1:2];
  assign updTag  = updPc_I[IDX_W+TAG_W+1:IDX_W+2];
  assign updHit  = validQ[updIdx]
                && (tagMem[updIdx] == updTag);
  assign wrEn    = updValid_I && !flush_I
                && !reset_I;
  assign doAlloc = wrEn && !updHit && updTaken_I;
  assign doTrain = wrEn && updHit;
  assign curCtr  = ctrMem[updIdx];
  assign unusedPc = ^updPc_I;

  assign allocCtr = updIsJump_I ? CTR_MAX : CTR_WKT;

  always_comb begin
    trainCtr = curCtr;
    unique case (1'b1)
      updIsJump_I:
        trainCtr = CTR_MAX;
      (!updIsJump_I && updTaken_I):
        trainCtr = (curCtr == CTR_MAX)
                 ? curCtr
                 : curCtr + CTR_W'(1);
      default:
        trainCtr = (curCtr == '0)
                 ? curCtr
                 : curCtr - CTR_W'(1);
    endcase
  end

  // Valid bits and counters carry reset state
  always_ff @(posedge clk_I or posedge reset_I) begin
    if (reset_I) begin
      validQ <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctrMem[i] <= CTR_WKNT;
      end
    end else if (flush_I) begin
      validQ <= '0;
    end else if (doAlloc) begin
      validQ[updIdx] <= 1'b1;
      ctrMem[updIdx] <= allocCtr;
    end else if (doTrain) begin
      ctrMem[updIdx] <= trainCtr;
    end
  end

  // Tag/target payload is only meaningful behind a valid bit
  always_ff @(posedge clk_I) begin
    if (doAlloc) begin
      tagMem[updIdx] <= updTag;
      tgtMem[updIdx] <= updTarget_I;
    end else if (doTrain && updTaken_I) begin
      tgtMem[updIdx] <= updTarget_I;
    end
  end

  // Statistics
  logic isMispred;

  assign isMispred =
    (updPredTaken_I != updTaken_I)
    || (updPredTaken_I && updTaken_I
        && (updPredTarget_I != updTarget_I));

  always_ff @(posedge clk_I or posedge reset_I) begin
    if (reset_I) begin
      branchCount_O  <= '0;
      mispredCount_O <= '0;
    end else if (updValid_I) begin
      if (branchCount_O != STAT_MAX) begin
        branchCount_O <= branchCount_O + STAT_W'(1);
      end
      if (isMispred && (mispredCount_O != STAT_MAX)) begin
        mispredCount_O <= mispredCount_O + STAT_W'(1);
      end
    end
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16: number of predictor entries; power of 2, minimum 2.
REQ-002 SHALL have parameter TAG_W, default 8: width of the stored tag.
REQ-003 SHALL have parameter CTR_W, default 2: width of the saturating direction counter; minimum 1.
REQ-004 SHALL have parameter STAT_W, default 16: width of the statistics counters.
REQ-005 SHALL define IDX_W = log2(ENTRIES); index = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2].
REQ-006 clk_I  in  1  clock; all state updates occur on the rising edge.
REQ-007 reset_I  in  1  reset; asynchronous, active-high.
REQ-008 ifPc_I  in  32  fetch-stage PC to look up.
REQ-009 predTaken_O  out  1  predicted taken for ifPc_I.
REQ-010 predTarget_O  out  32  predicted next PC.
REQ-011 updValid_I  in  1  a resolved branch or jump is in MEM this cycle.
REQ-012 updPc_I  in  32  PC of the resolved instruction.
REQ-013 updTaken_I  in  1  actual outcome of the resolved instruction.
REQ-014 updTarget_I  in  32  actual target of the resolved instruction.
REQ-015 updIsJump_I  in  1  resolved instruction is JAL/JALR.
REQ-016 updPredTaken_I  in  1  prediction made for this instruction at fetch.
REQ-017 updPredTarget_I  in  32  predicted target for this instruction at fetch.
REQ-018 flush_I  in  1  invalidate the whole table.
REQ-019 branchCount_O  out  STAT_W  number of updates seen.
REQ-020 mispredCount_O  out  STAT_W  number of mispredictions seen.

Function
REQ-021 Each entry SHALL hold: valid (1 bit), tag (TAG_W bits), target (32 bits), ctr (CTR_W bits).
REQ-022 Lookup SHALL be combinational, zero latency: hit = valid & tag match at the index of ifPc_I.
REQ-023 predTaken_O SHALL equal hit & ctr[CTR_W-1].
REQ-024 predTarget_O SHALL equal the stored target when predTaken_O=1, otherwise ifPc_I+4 (mod 2^32).
REQ-025 An update hitting its entry with updIsJump_I=0 SHALL increment ctr if updTaken_I=1 and decrement it otherwise, saturating at all-ones and at 0.
REQ-026 An update hitting its entry with updTaken_I=1 SHALL overwrite the stored target with updTarget_I.
REQ-027 An update with updIsJump_I=1 SHALL force ctr to all-ones.
REQ-028 An update missing its entry with updTaken_I=1 SHALL allocate the entry: valid=1, tag from updPc_I, target=updTarget_I, ctr=2^(CTR_W-1) (weakly taken), or all-ones if updIsJump_I=1.
REQ-029 An update missing its entry with updTaken_I=0 SHALL leave the table unchanged.
REQ-030 A lookup and an update to the same entry in the same cycle: the lookup SHALL return pre-update contents; there is no bypass.
REQ-031 flush_I=1 SHALL clear all valid bits in one cycle and SHALL take priority over a same-cycle update; the statistics counters still count that update.
REQ-032 branchCount_O SHALL increment by 1 per cycle with updValid_I=1.
REQ-033 mispredCount_O SHALL increment by 1 when updValid_I=1 and either:
  - updPredTaken_I != updTaken_I, or
  - both are 1 and updPredTarget_I != updTarget_I.
REQ-034 Both statistics counters SHALL saturate at 2^STAT_W-1 and SHALL not wrap.
REQ-035 Inputs SHALL be ignored while updValid_I=0, except flush_I.

Reset
REQ-036 While reset_I=1, every valid bit SHALL be 0, every ctr SHALL be 2^(CTR_W-1)-1 (weakly not-taken), and both statistics counters SHALL be 0.
REQ-037 While reset_I=1, predTaken_O SHALL be 0 and predTarget_O SHALL equal ifPc_I+4.
REQ-038 Reset asserted mid-sequence SHALL discard any update sampled in the same cycle.

Verification
REQ-039 Post-reset lookup, ifPc_I=0x40 -> predTaken_O=0, predTarget_O=0x44, both counts 0.
REQ-040 Taken update at pc=0x40, target=0x100, updPredTaken_I=0; next cycle look up 0x40 -> predTaken_O=1, predTarget_O=0x100, branchCount_O=1, mispredCount_O=1.
REQ-041 Two not-taken updates at 0x40 following REQ-040 -> ctr=0; lookup 0x40 -> predTaken_O=0, predTarget_O=0x44; the entry remains valid.
REQ-042 Aliasing: with 0x40 allocated, look up 0x1040 (same index, tag 0x41 vs 0x01) -> miss, predTarget_O=0x1044.
REQ-043 Four taken updates at 0x40 then one not-taken -> ctr=2'b10; lookup still predicts taken at the stored target.
REQ-044 flush_I and a taken update in the same cycle -> every lookup misses afterward, and branchCount_O still increments.
